// File: rtl/nqcpu_pkg.sv
// nqcpu_pkg: shared types and constants for the register-file write side.
//   REG_BANK   - destination index of the bank register (GPRs are 0-7)
//   NUM_WREGS  - number of writable destinations tracked (GPR0-7 + bank)
//   wb_req_t   - one register-file write: dest, data, high/low byte strobes
//   wb_gnt_e   - which source owns the write port in a given cycle
package nqcpu_pkg;

  localparam logic [3:0]  REG_BANK  = 4'h8;
  localparam int unsigned NUM_WREGS = 9;

  typedef struct packed {
    logic [3:0]  dest;
    logic [15:0] data;
    logic        hb;
    logic        lb;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_ALU,
    GNT_LOAD
  } wb_gnt_e;

  // True for any destination that exists in the register file.
  function automatic logic dest_in_range(input logic [3:0] d);
    return d <= REG_BANK;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small load-return FIFO of wb_req_t entries.
//   clk_i    - clock, rising edge
//   rst_ni   - asynchronous active-low reset, empties the FIFO
//   push_i   - write data_i; accepted when not full, or when full and popping
//   data_i   - entry to push
//   pop_i    - drop the head entry (ignored when empty)
//   full_o   - all DEPTH entries occupied
//   empty_o  - no entries
//   head_o   - oldest entry, read straight from the storage registers
module wb_fifo
  import nqcpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    push_i,
  input  wb_req_t data_i,
  input  logic    pop_i,
  output logic    full_o,
  output logic    empty_o,
  output wb_req_t head_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_req_t        mem_q [DEPTH];
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic           do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push_i & (~full_o | do_pop);

  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: owns the single regFile write port and shares it
// between ALU writeback and buffered memory load returns, and tracks which
// destinations have a load outstanding so decode can stall on them.
//   clk, reset_n              - clock; asynchronous active-low reset
//   alu_valid/ready/dest/data/hb/lb
//                             - ALU writeback request; ready is combinational
//                               and means the request is taken at this edge
//   mem_valid/dest/data/hb/lb - load return, always pushed into the FIFO
//   ld_issue, ld_dest         - load sent to memory; dest becomes pending
//   chk_a, chk_b, chk_dest    - decode operands checked against pending loads
//   stall                     - decode hazard (combinational)
//   rf_we/dest/data/hb/lb     - registered write to regFile
//   lq_overflow               - sticky: a load return was dropped
//   ld_err                    - sticky: load issued to a pending or bad dest
module regfile_wb_arbiter
  import nqcpu_pkg::*;
#(
  parameter int unsigned LQ_DEPTH     = 2,
  parameter int unsigned STARVE_LIMIT = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [3:0]  alu_dest,
  input  logic [15:0] alu_data,
  input  logic        alu_hb,
  input  logic        alu_lb,
  input  logic        mem_valid,
  input  logic [3:0]  mem_dest,
  input  logic [15:0] mem_data,
  input  logic        mem_hb,
  input  logic        mem_lb,
  input  logic        ld_issue,
  input  logic [3:0]  ld_dest,
  input  logic [2:0]  chk_a,
  input  logic [2:0]  chk_b,
  input  logic [3:0]  chk_dest,
  output logic        stall,
  output logic        rf_we,
  output logic [3:0]  rf_dest,
  output logic [15:0] rf_data,
  output logic        rf_hb,
  output logic        rf_lb,
  output logic        lq_overflow,
  output logic        ld_err
);

  // Counter must be able to hold STARVE_LIMIT itself (and never be 0 wide).
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 2);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  wb_req_t              alu_req, mem_req, lq_head, wr_req;
  logic                 lq_full, lq_empty, lq_pop;
  wb_gnt_e              gnt;

  logic [SW-1:0]        starve_q, starve_d;
  logic [NUM_WREGS-1:0] pending_q, pending_d;
  logic                 lq_overflow_q, lq_overflow_d;
  logic                 ld_err_q, ld_err_d;
  logic                 rf_we_q;
  wb_req_t              rf_q;

  assign alu_req = '{dest: alu_dest, data: alu_data, hb: alu_hb, lb: alu_lb};
  assign mem_req = '{dest: mem_dest, data: mem_data, hb: mem_hb, lb: mem_lb};

  wb_fifo #(
    .DEPTH(LQ_DEPTH)
  ) u_lq (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (mem_valid),
    .data_i  (mem_req),
    .pop_i   (lq_pop),
    .full_o  (lq_full),
    .empty_o (lq_empty),
    .head_o  (lq_head)
  );

  // Loads win because they cannot be back-pressured; the ALU only breaks in
  // once it has watched STARVE_LIMIT load grants go by.
  always_comb begin
    gnt = GNT_NONE;
    if (alu_valid && (lq_empty || (starve_q == STARVE_MAX))) begin
      gnt = GNT_ALU;
    end else if (!lq_empty) begin
      gnt = GNT_LOAD;
    end
  end

  assign alu_ready = (gnt == GNT_ALU);
  assign lq_pop    = (gnt == GNT_LOAD);
  assign wr_req    = (gnt == GNT_ALU) ? alu_req : lq_head;

  always_comb begin
    starve_d = starve_q;
    if ((gnt == GNT_LOAD) && alu_valid) begin
      starve_d = starve_q + 1'b1;
    end else if ((gnt == GNT_ALU) || !alu_valid) begin
      starve_d = '0;
    end
  end

  assign lq_overflow_d = lq_overflow_q | (mem_valid & lq_full & ~lq_pop);

  // Clear from the retiring load is applied first so a same-edge issue to
  // the same dest leaves it pending. The error check uses the old state.
  always_comb begin
    pending_d = pending_q;
    ld_err_d  = ld_err_q;
    if ((gnt == GNT_LOAD) && dest_in_range(lq_head.dest)) begin
      pending_d[lq_head.dest] = 1'b0;
    end
    if (ld_issue) begin
      if (!dest_in_range(ld_dest)) begin
        ld_err_d = 1'b1;
      end else begin
        if (pending_q[ld_dest]) ld_err_d = 1'b1;
        pending_d[ld_dest] = 1'b1;
      end
    end
  end

  assign stall = pending_q[{1'b0, chk_a}] |
                 pending_q[{1'b0, chk_b}] |
                 (dest_in_range(chk_dest) & pending_q[chk_dest]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q      <= '0;
      pending_q     <= '0;
      lq_overflow_q <= 1'b0;
      ld_err_q      <= 1'b0;
      rf_we_q       <= 1'b0;
      rf_q          <= '0;
    end else begin
      starve_q      <= starve_d;
      pending_q     <= pending_d;
      lq_overflow_q <= lq_overflow_d;
      ld_err_q      <= ld_err_d;
      rf_we_q       <= (gnt != GNT_NONE);
      // Write fields hold their last value when the port is idle.
      if (gnt != GNT_NONE) rf_q <= wr_req;
    end
  end

  assign rf_we       = rf_we_q;
  assign rf_dest     = rf_q.dest;
  assign rf_data     = rf_q.data;
  assign rf_hb       = rf_q.hb;
  assign rf_lb       = rf_q.lb;
  assign lq_overflow = lq_overflow_q;
  assign ld_err      = ld_err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int unsigned LQD = 2;
  localparam int unsigned SL  = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_valid, alu_ready, alu_hb, alu_lb;
  logic [3:0]  alu_dest;
  logic [15:0] alu_data;
  logic        mem_valid, mem_hb, mem_lb;
  logic [3:0]  mem_dest;
  logic [15:0] mem_data;
  logic        ld_issue;
  logic [3:0]  ld_dest;
  logic [2:0]  chk_a, chk_b;
  logic [3:0]  chk_dest;
  logic        stall, rf_we, rf_hb, rf_lb, lq_overflow, ld_err;
  logic [3:0]  rf_dest;
  logic [15:0] rf_data;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .LQ_DEPTH     (LQD),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_dest    (alu_dest),
    .alu_data    (alu_data),
    .alu_hb      (alu_hb),
    .alu_lb      (alu_lb),
    .mem_valid   (mem_valid),
    .mem_dest    (mem_dest),
    .mem_data    (mem_data),
    .mem_hb      (mem_hb),
    .mem_lb      (mem_lb),
    .ld_issue    (ld_issue),
    .ld_dest     (ld_dest),
    .chk_a       (chk_a),
    .chk_b       (chk_b),
    .chk_dest    (chk_dest),
    .stall       (stall),
    .rf_we       (rf_we),
    .rf_dest     (rf_dest),
    .rf_data     (rf_data),
    .rf_hb       (rf_hb),
    .rf_lb       (rf_lb),
    .lq_overflow (lq_overflow),
    .ld_err      (ld_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: load queue as a plain queue, scoreboard as a bit array.
  typedef struct {
    int unsigned d;
    int unsigned v;
    bit          hb;
    bit          lb;
  } req_t;

  req_t        q[$];
  bit          pend[9];
  int unsigned starve;
  bit          m_ovf, m_err, m_we, m_hb, m_lb;
  int unsigned m_dest, m_data;
  bit          alu_taken;

  task automatic model_reset();
    q.delete();
    foreach (pend[i]) pend[i] = 1'b0;
    starve = 0; m_ovf = 0; m_err = 0; m_we = 0; m_hb = 0; m_lb = 0;
    m_dest = 0; m_data = 0; alu_taken = 0;
  endtask

  function automatic bit m_alu_wins();
    return alu_valid && (q.size() == 0 || starve == SL);
  endfunction

  function automatic bit m_stall();
    bit s;
    s = pend[chk_a] | pend[chk_b];
    if (chk_dest <= 8) s = s | pend[chk_dest];
    return s;
  endfunction

  task automatic model_edge();
    bit aw, lw;
    req_t h, r;
    aw = m_alu_wins();
    lw = (q.size() > 0) && !aw;
    if (ld_issue) begin
      if (ld_dest > 8) m_err = 1;
      else if (pend[ld_dest]) m_err = 1;
    end
    if (aw) begin
      m_we = 1; m_dest = alu_dest; m_data = alu_data; m_hb = alu_hb; m_lb = alu_lb;
    end else if (lw) begin
      h = q.pop_front();
      m_we = 1; m_dest = h.d; m_data = h.v; m_hb = h.hb; m_lb = h.lb;
      if (h.d <= 8) pend[h.d] = 0;
    end else begin
      m_we = 0;
    end
    if (ld_issue && ld_dest <= 8) pend[ld_dest] = 1;
    starve = (lw && alu_valid) ? starve + 1 : 0;
    if (mem_valid) begin
      if (q.size() < LQD) begin
        r.d = mem_dest; r.v = mem_data; r.hb = mem_hb; r.lb = mem_lb;
        q.push_back(r);
      end else begin
        m_ovf = 1;
      end
    end
    alu_taken = aw;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle(input string tag);
    #1;
    check($sformatf("%s.alu_ready", tag), 32'(alu_ready), 32'(m_alu_wins()));
    check($sformatf("%s.stall", tag), 32'(stall), 32'(m_stall()));
    @(posedge clk);
    model_edge();
    #1;
    check($sformatf("%s.rf_we", tag), 32'(rf_we), 32'(m_we));
    check($sformatf("%s.rf_dest", tag), 32'(rf_dest), m_dest);
    check($sformatf("%s.rf_data", tag), 32'(rf_data), m_data);
    check($sformatf("%s.rf_hb", tag), 32'(rf_hb), 32'(m_hb));
    check($sformatf("%s.rf_lb", tag), 32'(rf_lb), 32'(m_lb));
    check($sformatf("%s.lq_overflow", tag), 32'(lq_overflow), 32'(m_ovf));
    check($sformatf("%s.ld_err", tag), 32'(ld_err), 32'(m_err));
    @(negedge clk);
  endtask

  task automatic drive_idle();
    alu_valid = 0; alu_dest = 0; alu_data = 0; alu_hb = 0; alu_lb = 0;
    mem_valid = 0; mem_dest = 0; mem_data = 0; mem_hb = 0; mem_lb = 0;
    ld_issue = 0; ld_dest = 0; chk_a = 0; chk_b = 0; chk_dest = 0;
  endtask

  // Asserts reset at the current time without touching the inputs.
  task automatic do_reset(input string tag);
    reset_n = 0;
    #1;
    model_reset();
    check($sformatf("%s.rf_we", tag), 32'(rf_we), 32'd0);
    check($sformatf("%s.stall", tag), 32'(stall), 32'd0);
    check($sformatf("%s.lq_overflow", tag), 32'(lq_overflow), 32'd0);
    check($sformatf("%s.ld_err", tag), 32'(ld_err), 32'd0);
    check($sformatf("%s.rf_fields", tag), {rf_dest, rf_data, rf_hb, rf_lb}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic rand_inputs(input int unsigned p_alu, input int unsigned p_mem);
    if (!alu_valid || alu_taken) begin
      alu_valid = ($urandom_range(0, 99) < p_alu);
      alu_dest  = 4'($urandom_range(0, 8));
      alu_data  = 16'($urandom);
      alu_hb    = 1'($urandom);
      alu_lb    = 1'($urandom);
    end
    mem_valid = ($urandom_range(0, 99) < p_mem);
    mem_dest  = 4'($urandom_range(0, 9));
    mem_data  = 16'($urandom);
    mem_hb    = 1'($urandom);
    mem_lb    = 1'($urandom);
    ld_issue  = ($urandom_range(0, 99) < 25);
    ld_dest   = 4'($urandom_range(0, 9));
    chk_a     = 3'($urandom);
    chk_b     = 3'($urandom);
    chk_dest  = 4'($urandom_range(0, 15));
  endtask

  initial begin
    int unsigned order, ngr, nalu, nload, nlost;
    bit alu_done;

    drive_idle();
    reset_n = 0;
    model_reset();
    @(negedge clk);
    do_reset("rst");
    check("rst.alu_ready_idle", 32'(alu_ready), 32'd0);

    // 1: single ALU write
    alu_valid = 1; alu_dest = 4'd1; alu_data = 16'hDEAD; alu_hb = 1; alu_lb = 1;
    #1 check("t1.ready_same_cycle", 32'(alu_ready), 32'd1);
    cycle("t1a");
    check("t1.data", 32'(rf_data), 32'hDEAD);
    check("t1.dest", 32'(rf_dest), 32'd1);
    drive_idle();
    cycle("t1b");
    check("t1.we_drop", 32'(rf_we), 32'd0);

    // 2: load to r2, stall until grant
    ld_issue = 1; ld_dest = 4'd2; chk_a = 3'd2;
    cycle("t2a");
    ld_issue = 0;
    check("t2.stall", 32'(stall), 32'd1);
    mem_valid = 1; mem_dest = 4'd2; mem_data = 16'h9876; mem_hb = 1; mem_lb = 1;
    cycle("t2b");
    check("t2.no_bypass", 32'(rf_we), 32'd0);
    mem_valid = 0;
    cycle("t2c");
    check("t2.we", 32'(rf_we), 32'd1);
    check("t2.data", 32'(rf_data), 32'h9876);
    check("t2.stall_drop", 32'(stall), 32'd0);
    drive_idle();
    cycle("t2d");

    // 3: four load returns against a held ALU request
    order = 0; ngr = 0; nalu = 0; alu_done = 0;
    for (int i = 0; i < 8; i++) begin
      mem_valid = (i <= 3); mem_dest = 4'd7; mem_data = 16'(32'h7000 + i);
      mem_hb = 1; mem_lb = 1;
      alu_valid = (i >= 1) && !alu_done;
      alu_dest = 4'd6; alu_data = 16'hA1A1; alu_hb = 1; alu_lb = 0;
      cycle($sformatf("t3_%0d", i));
      if (alu_taken) alu_done = 1;
      if (rf_we) begin
        order = (order << 1) | 32'(rf_data == 16'hA1A1);
        ngr++;
        if (rf_data == 16'hA1A1) nalu++;
      end
    end
    check("t3.order", order, 32'b00100);
    check("t3.grants", ngr, 32'd5);
    check("t3.alu_once", nalu, 32'd1);
    check("t3.no_ovf", 32'(lq_overflow), 32'd0);
    drive_idle();

    // 4: sustained ALU pressure with back-to-back returns fills the FIFO
    do_reset("t4rst");
    nload = 0; nlost = 0;
    alu_dest = 4'd6; alu_data = 16'hB000; alu_hb = 1; alu_lb = 1;
    for (int i = 0; i < 10; i++) begin
      if (alu_taken) alu_data = 16'(32'hB000 + i);
      alu_valid = (i <= 6);
      mem_valid = (i <= 6); mem_dest = 4'd5; mem_data = 16'(32'h5000 + i);
      mem_hb = 0; mem_lb = 1;
      cycle($sformatf("t4_%0d", i));
      if (rf_we && rf_dest == 4'd5) nload++;
      if (rf_we && rf_data == 16'h5006) nlost++;
    end
    check("t4.ovf", 32'(lq_overflow), 32'd1);
    check("t4.loads_written", nload, 32'd6);
    check("t4.dropped_absent", nlost, 32'd0);
    drive_idle();

    // 5: bank register load
    ld_issue = 1; ld_dest = 4'd8; chk_dest = 4'd8;
    cycle("t5a");
    ld_issue = 0;
    check("t5.stall", 32'(stall), 32'd1);
    mem_valid = 1; mem_dest = 4'd8; mem_data = 16'hEFAC; mem_hb = 0; mem_lb = 1;
    cycle("t5b");
    check("t5.stall_hold", 32'(stall), 32'd1);
    mem_valid = 0;
    cycle("t5c");
    check("t5.dest", 32'(rf_dest), 32'd8);
    check("t5.strobes", {30'd0, rf_hb, rf_lb}, 32'b01);
    check("t5.stall_drop", 32'(stall), 32'd0);
    drive_idle();

    // 6: double issue error, then reset with the FIFO occupied
    ld_issue = 1; ld_dest = 4'd3;
    cycle("t6a");
    cycle("t6b");
    ld_issue = 0;
    check("t6.ld_err", 32'(ld_err), 32'd1);
    chk_a = 3'd3;
    alu_valid = 1; alu_dest = 4'd1; alu_data = 16'h1111; alu_hb = 1; alu_lb = 1;
    mem_valid = 1; mem_dest = 4'd4; mem_data = 16'h4444; mem_hb = 1; mem_lb = 1;
    cycle("t6c");
    alu_data = 16'h2222;
    cycle("t6d");
    check("t6.pre_stall", 32'(stall), 32'd1);
    mem_valid = 0;
    do_reset("t6rst");
    check("t6.fifo_empty", 32'(alu_ready), 32'd1);
    cycle("t6e");
    alu_valid = 0;
    for (int i = 0; i < 3; i++) cycle($sformatf("t6f_%0d", i));

    // Randomised traffic, normal then heavy load
    drive_idle();
    do_reset("r1rst");
    for (int i = 0; i < 1500; i++) begin
      rand_inputs(60, 45);
      cycle("rnd1");
    end
    drive_idle();
    do_reset("r2rst");
    for (int i = 0; i < 1500; i++) begin
      rand_inputs(90, 85);
      cycle("rnd2");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
